// File: rtl/mm_addr_gen.sv
// mm_addr_gen: sequences DIM/LOAD_A/LOAD_B/STORE_C dmem commands for C = A x B.
// Optional MM_PERF_CNT_EN adds a saturating perf_stall backpressure counter.
`default_nettype none

module mm_addr_gen #(
    parameter int                ADDR_W    = 32,
    parameter int                DIM_W     = 10,
    parameter int                BLK_WORDS = 8,
    parameter logic [ADDR_W-1:0] A_BASE    = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] B_BASE    = 32'h0000_1400,
    parameter logic [ADDR_W-1:0] C_BASE    = 32'h0000_2800,
    parameter logic [ADDR_W-1:0] DIM_ADDR  = 32'h0000_3C00
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              dim_we,
    input  logic [31:0]       dim_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              mm_en,
    output logic              busy,
    output logic              done,
    output logic              err,
`ifdef MM_PERF_CNT_EN
    output logic [31:0]       dims,
    output logic [31:0]       perf_stall
`else
    output logic [31:0]       dims
`endif
);

    localparam int LG = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 0;
    localparam int KW = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    localparam logic [ADDR_W-1:0] BLK_BYTES = ADDR_W'(4 * BLK_WORDS);
    localparam logic [DIM_W-1:0]  BLK_MASK  = DIM_W'(BLK_WORDS - 1);
    localparam logic [KW-1:0]     K_LAST    = KW'(BLK_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DIM_REQ, S_DIM_WAIT, S_CHECK, S_LD_A, S_LD_B, S_ST_C, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  i_q, i_d, jb_q, jb_d, kb_q, kb_d;
    logic [KW-1:0]     k_q, k_d;
    logic [ADDR_W-1:0] a_row_q, a_row_d, a_koff_q, a_koff_d;
    logic [ADDR_W-1:0] b_ptr_q, b_ptr_d, jb_off_q, jb_off_d, c_ptr_q, c_ptr_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [1:0]        cmd_type_q, cmd_type_d;
    logic [31:0]       dims_q, dims_d;
    logic              err_q, err_d;

    logic [DIM_W-1:0]  m_w, n_w, o_w, m_last_w, nb_last_w, ob_last_w;
    logic [ADDR_W-1:0] a_stride_w, b_stride_w;
    logic              xfer_w, dim_bad_w;

    assign m_w        = dims_q[DIM_W-1:0];
    assign n_w        = dims_q[2*DIM_W-1:DIM_W];
    assign o_w        = dims_q[3*DIM_W-1:2*DIM_W];
    assign m_last_w   = m_w - DIM_W'(1);
    assign nb_last_w  = (n_w >> LG) - DIM_W'(1);
    assign ob_last_w  = (o_w >> LG) - DIM_W'(1);
    assign a_stride_w = ADDR_W'(n_w) << 2;
    assign b_stride_w = ADDR_W'(o_w) << 2;
    assign dim_bad_w  = (m_w == '0) || (n_w == '0) || (o_w == '0) ||
                        ((n_w & BLK_MASK) != '0) || ((o_w & BLK_MASK) != '0);

    assign cmd_valid = (state_q == S_DIM_REQ) || (state_q == S_LD_A) ||
                       (state_q == S_LD_B)    || (state_q == S_ST_C);
    assign mm_en     = (state_q == S_LD_A) || (state_q == S_LD_B) || (state_q == S_ST_C);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign dims      = dims_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_type  = cmd_type_q;
    assign xfer_w    = cmd_valid & cmd_ready;

    // B and C pointers advance linearly; only A needs a row base plus block offset.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        jb_d     = jb_q;
        kb_d     = kb_q;
        k_d      = k_q;
        a_row_d  = a_row_q;
        a_koff_d = a_koff_q;
        b_ptr_d  = b_ptr_q;
        jb_off_d = jb_off_q;
        c_ptr_d  = c_ptr_q;
        dims_d   = dims_q;
        err_d    = err_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_d = S_DIM_REQ;
                    err_d   = 1'b0;
                end
                S_DIM_REQ: if (xfer_w) state_d = S_DIM_WAIT;
                S_DIM_WAIT: if (dim_we) begin
                    dims_d  = dim_data;
                    state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (dim_bad_w) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        i_d      = '0;
                        jb_d     = '0;
                        kb_d     = '0;
                        k_d      = '0;
                        a_row_d  = A_BASE;
                        a_koff_d = '0;
                        b_ptr_d  = B_BASE;
                        jb_off_d = '0;
                        c_ptr_d  = C_BASE;
                        state_d  = S_LD_A;
                    end
                end
                S_LD_A: if (xfer_w) begin
                    k_d     = '0;
                    state_d = S_LD_B;
                end
                S_LD_B: if (xfer_w) begin
                    b_ptr_d = b_ptr_q + b_stride_w;
                    k_d     = k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        if (kb_q < nb_last_w) begin
                            kb_d     = kb_q + DIM_W'(1);
                            a_koff_d = a_koff_q + BLK_BYTES;
                            state_d  = S_LD_A;
                        end else begin
                            state_d = S_ST_C;
                        end
                    end
                end
                S_ST_C: if (xfer_w) begin
                    kb_d     = '0;
                    a_koff_d = '0;
                    c_ptr_d  = c_ptr_q + BLK_BYTES;
                    if (jb_q < ob_last_w) begin
                        jb_d     = jb_q + DIM_W'(1);
                        jb_off_d = jb_off_q + BLK_BYTES;
                        b_ptr_d  = B_BASE + jb_off_q + BLK_BYTES;
                        state_d  = S_LD_A;
                    end else if (i_q < m_last_w) begin
                        i_d      = i_q + DIM_W'(1);
                        jb_d     = '0;
                        jb_off_d = '0;
                        a_row_d  = a_row_q + a_stride_w;
                        b_ptr_d  = B_BASE;
                        state_d  = S_LD_A;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        cmd_addr_d = '0;
        cmd_type_d = 2'd0;
        case (state_d)
            S_DIM_REQ: cmd_addr_d = DIM_ADDR;
            S_LD_A: begin
                cmd_addr_d = a_row_d + a_koff_d;
                cmd_type_d = 2'd1;
            end
            S_LD_B: begin
                cmd_addr_d = b_ptr_d;
                cmd_type_d = 2'd2;
            end
            S_ST_C: begin
                cmd_addr_d = c_ptr_d;
                cmd_type_d = 2'd3;
            end
            default: cmd_addr_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            jb_q       <= '0;
            kb_q       <= '0;
            k_q        <= '0;
            a_row_q    <= '0;
            a_koff_q   <= '0;
            b_ptr_q    <= '0;
            jb_off_q   <= '0;
            c_ptr_q    <= '0;
            cmd_addr_q <= '0;
            cmd_type_q <= 2'd0;
            dims_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            jb_q       <= jb_d;
            kb_q       <= kb_d;
            k_q        <= k_d;
            a_row_q    <= a_row_d;
            a_koff_q   <= a_koff_d;
            b_ptr_q    <= b_ptr_d;
            jb_off_q   <= jb_off_d;
            c_ptr_q    <= c_ptr_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_type_q <= cmd_type_d;
            dims_q     <= dims_d;
            err_q      <= err_d;
        end
    end

`ifdef MM_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == S_IDLE) && start && !abort) begin
            perf_d = '0;
        end else if (cmd_valid && !cmd_ready && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) perf_q <= '0;
        else          perf_q <= perf_d;
    end

    assign perf_stall = perf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mm_addr_gen.sv
// Scoreboard bench for mm_addr_gen: expected commands are queued per run, a monitor checks each transfer.
`default_nettype none

module tb_mm_addr_gen;
    logic        clk = 1'b0;
    logic        reset_n, start, abort, cmd_ready;
    logic        dim_we   = 1'b0;
    logic [31:0] dim_data = 32'd0;
    logic        cmd_valid, mm_en, busy, done, err;
    logic [1:0]  cmd_type;
    logic [31:0] cmd_addr, dims;
`ifdef MM_PERF_CNT_EN
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    mm_addr_gen dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .dim_we(dim_we), .dim_data(dim_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
        .mm_en(mm_en), .busy(busy), .done(done), .err(err),
`ifdef MM_PERF_CNT_EN
        .dims(dims), .perf_stall(perf_stall)
`else
        .dims(dims)
`endif
    );

    int          cyc = 0;
    int          total = 0, bad = 0;
    int          done_cnt = 0, done_cyc = 0, xfer_cyc = 0, we_cyc = 0;
    logic [31:0] dims_in = 32'd0;
    logic [33:0] exp_q[$];
    logic [33:0] log_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor: every accepted command is compared against the head of the queue.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (reset_n && cmd_valid && cmd_ready && !abort) begin
            log_q.push_back({cmd_type, cmd_addr});
            xfer_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_cmd: got type %0d addr %0h, expected none", cmd_type, cmd_addr);
            end else begin
                chk("cmd", {30'd0, cmd_type, cmd_addr}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    // Memory side: answer a DIM command with the dimension word on the next cycle.
    always @(negedge clk) begin
        if (reset_n && cmd_valid && cmd_ready && !abort && cmd_type == 2'd0) begin
            @(posedge clk);
            #1;
            dim_we   = 1'b1;
            dim_data = dims_in;
            we_cyc   = cyc;
            @(posedge clk);
            #1;
            dim_we = 1'b0;
        end
    end

    task automatic push_model(input int m, input int n, input int o, input bit err_exp);
        exp_q.push_back({2'd0, 32'h0000_3C00});
        if (!err_exp) begin
            for (int i = 0; i < m; i++)
                for (int jb = 0; jb < o / 8; jb++) begin
                    for (int kb = 0; kb < n / 8; kb++) begin
                        exp_q.push_back({2'd1, 32'(4 * (i * n + kb * 8))});
                        for (int k = 0; k < 8; k++)
                            exp_q.push_back({2'd2, 32'(32'h1400 + 4 * ((kb * 8 + k) * o + jb * 8))});
                    end
                    exp_q.push_back({2'd3, 32'(32'h2800 + 4 * (i * o + jb * 8))});
                end
        end
    endtask

    task automatic setup(input int m, input int n, input int o, input bit err_exp);
        log_q.delete();
        exp_q.delete();
        dims_in = 32'(m) | (32'(n) << 10) | (32'(o) << 20);
        push_model(m, n, o, err_exp);
    endtask

    task automatic pulse_start;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_type(input logic [1:0] t, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (cmd_valid && cmd_type == t) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_case(input int m, input int n, input int o, input bit err_exp, input string tag);
        bit ok;
        int d0;
        setup(m, n, o, err_exp);
        d0 = done_cnt;
        pulse_start();
        wait_idle(ok);
        chk({tag, "_finished"}, 64'(ok), 64'd1);
        if (err_exp) begin
            chk({tag, "_err"}, 64'(err), 64'd1);
            chk({tag, "_no_done"}, 64'(done_cnt - d0), 64'd0);
            chk({tag, "_idle_lat_ok"}, 64'((cyc - we_cyc) <= 2), 64'd1);
        end else begin
            chk({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
            chk({tag, "_err"}, 64'(err), 64'd0);
            chk({tag, "_done_timing"}, 64'(done_cyc), 64'(xfer_cyc + 1));
        end
        chk({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_mm_en_idle"}, 64'(mm_en), 64'd0);
    endtask

    initial begin
        bit ok;
        logic [31:0] a0;
        int d0;
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cmd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_busy_done_en_err", 64'({busy, done, mm_en, err}), 64'd0);
        chk("rst_addr_type", 64'({cmd_type, cmd_addr}), 64'd0);
        chk("rst_dims", 64'(dims), 64'd0);
        @(posedge clk); #1; reset_n = 1'b1;

        run_case(1, 8, 8, 1'b0, "m1n8o8");
        chk("m1_count", 64'(log_q.size()), 64'd11);
        if (log_q.size() == 11) begin
            chk("m1_dim", 64'(log_q[0]), 64'({2'd0, 32'h3C00}));
            chk("m1_lastB", 64'(log_q[9]), 64'({2'd2, 32'h14E0}));
            chk("m1_C", 64'(log_q[10]), 64'({2'd3, 32'h2800}));
        end

        run_case(2, 16, 16, 1'b0, "m2n16o16");
        chk("m2_count", 64'(log_q.size()), 64'd77);
        if (log_q.size() == 77) begin
            chk("m2_A2", 64'(log_q[10]), 64'({2'd1, 32'h0020}));
            chk("m2_Bkb1", 64'(log_q[11]), 64'({2'd2, 32'h1600}));
            chk("m2_lastC", 64'(log_q[76]), 64'({2'd3, 32'h2860}));
        end

        run_case(1, 12, 8, 1'b1, "n12");
        chk("n12_only_dim", 64'(log_q.size()), 64'd1);
        run_case(0, 8, 8, 1'b1, "m0");
        chk("m0_only_dim", 64'(log_q.size()), 64'd1);

        // Backpressure mid LD_B, with a start pulse that must be ignored.
        setup(1, 8, 8, 1'b0);
        d0 = done_cnt;
        pulse_start();
        wait_type(2'd2, ok);
        chk("bp_reach_ldb", 64'(ok), 64'd1);
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        a0 = cmd_addr;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            start = 1'b0;
            chk("bp_addr_stable", 64'(cmd_addr), 64'(a0));
            chk("bp_valid_held", 64'(cmd_valid), 64'd1);
        end
        @(posedge clk); #1; cmd_ready = 1'b1;
        wait_idle(ok);
        chk("bp_finished", 64'(ok), 64'd1);
        chk("bp_done", 64'(done_cnt - d0), 64'd1);
        chk("bp_queue_left", 64'(exp_q.size()), 64'd0);
`ifdef MM_PERF_CNT_EN
        chk("bp_perf_stall", 64'(perf_stall), 64'd5);
`endif

        // Abort during LD_B.
        setup(2, 16, 16, 1'b0);
        d0 = done_cnt;
        pulse_start();
        wait_type(2'd2, ok);
        chk("ab_reach_ldb", 64'(ok), 64'd1);
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("ab_valid_low", 64'(cmd_valid), 64'd0);
        chk("ab_busy_low", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        chk("ab_no_done", 64'(done_cnt - d0), 64'd0);
        run_case(1, 8, 8, 1'b0, "after_abort");
        if (log_q.size() >= 2) begin
            chk("ab_restart_dim", 64'(log_q[0]), 64'({2'd0, 32'h3C00}));
            chk("ab_restart_A", 64'(log_q[1]), 64'({2'd1, 32'h0000}));
        end else begin
            chk("ab_restart_count", 64'(log_q.size()), 64'd11);
        end

        // Asynchronous reset while a STORE_C is pending.
        setup(1, 8, 8, 1'b0);
        pulse_start();
        wait_type(2'd3, ok);
        chk("rs_reach_stc", 64'(ok), 64'd1);
        #1; reset_n = 1'b0;
        #1;
        chk("rs_valid_async", 64'(cmd_valid), 64'd0);
        chk("rs_outs_async", 64'({busy, mm_en, done, cmd_type, cmd_addr}), 64'd0);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("rs_start_ignored", 64'(busy), 64'd0);
        @(posedge clk); #1; reset_n = 1'b1;
        run_case(1, 8, 8, 1'b0, "after_reset");
        chk("rs_count", 64'(log_q.size()), 64'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
